// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_seq
// Summary  : Iterative restoring divider (signed/unsigned), one quotient bit
//            per clock, with EX stall request and flush annul.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int               CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_CNT_DONE = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH:0]   work_q;
    logic [WIDTH-1:0]   divisor_q;
    logic               signed_q;
    logic               neg_dvd_q;
    logic               neg_dvs_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH:0]   work_d;
    logic [WIDTH-1:0]   w_quot_raw;
    logic [WIDTH-1:0]   w_rem_raw;
    logic [WIDTH-1:0]   quot_d;
    logic [WIDTH-1:0]   rem_d;

    assign w_dvd_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    assign w_dvs_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

    // Top bit of the (W+1)-bit difference is the borrow: partial remainder < divisor.
    assign w_diff = work_q[2*WIDTH:WIDTH] - {1'b0, divisor_q};
    assign work_d = w_diff[WIDTH] ? {work_q[2*WIDTH-1:0], 1'b0}
                                  : {w_diff[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};

    assign w_quot_raw = work_q[WIDTH-1:0];
    assign w_rem_raw  = work_q[2*WIDTH:WIDTH+1];
    assign quot_d = (signed_q && (neg_dvd_q ^ neg_dvs_q)) ? (~w_quot_raw + WIDTH'(1)) : w_quot_raw;
    assign rem_d  = (signed_q && neg_dvd_q) ? (~w_rem_raw + WIDTH'(1)) : w_rem_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        cnt_q <= '0;
                        if (opdata2_i == '0) begin
                            state_q <= S_BYZERO;
                        end else begin
                            state_q   <= S_ON;
                            divisor_q <= w_dvs_mag;
                            signed_q  <= signed_div_i;
                            neg_dvd_q <= opdata1_i[WIDTH-1];
                            neg_dvs_q <= opdata2_i[WIDTH-1];
                            work_q    <= {{WIDTH{1'b0}}, w_dvd_mag, 1'b0};
                        end
                    end
                end
                // Zero divisor dwells two cycles so the result appears two edges after the start.
                S_BYZERO: begin
                    if (annul_i) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        cnt_q <= c_CNT_ONE;
                    end else begin
                        state_q  <= S_END;
                        cnt_q    <= '0;
                        result_q <= '0;
                        ready_q  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_CNT_DONE) begin
                        state_q  <= S_END;
                        cnt_q    <= '0;
                        result_q <= {rem_d, quot_d};
                        ready_q  <= 1'b1;
                    end else begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + c_CNT_ONE;
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        state_q  <= S_IDLE;
                        ready_q  <= 1'b0;
                        result_q <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q;

endmodule
`default_nettype wire

// File: doc/div_seq.md
# div_seq

Iterative divide sequencer for the execute stage. It accepts one signed or unsigned WIDTH-bit division at a time from the EX stage and runs a restoring shift-subtract loop that produces one quotient bit per clock. It drives the EX stall request while busy and returns {remainder, quotient} through a start/ready handshake. The pipeline controller uses the annul input to cancel an in-flight divide on a flush.

## Interface

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high (`RstEnable`); clears all state.
- signed_div_i  in  1  1 = two's-complement divide, 0 = unsigned.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  request; held high by EX until ready_o seen.
- annul_i  in  1  cancel current/pending divide (flush).
- result_o  out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; valid only while ready_o=1.
- ready_o  out  1  result valid.
- stallreq_o  out  1  combinational: start_i & ~ready_o; EX stall request.

## Operation

- Four states: IDLE, BYZERO, ON, END.
- IDLE:
  - start_i=1, annul_i=0, opdata2_i=0 → BYZERO.
  - start_i=1, annul_i=0, opdata2_i≠0 → ON. Latch operand magnitudes: if signed_div_i and the MSB is set, latch the two's-complement negation, else the raw value. Latch signed_div_i and both operand sign bits. cnt←0. Working register ← {W zeros, |dividend|, 1'b0} (2W+1 bits).
  - Otherwise stay in IDLE.
- BYZERO: → END with result 0 (quotient 0, remainder 0). annul_i=1 → IDLE instead.
- ON, annul_i=0, each cycle:
  - Compute diff = work[2W:W] − {1'b0,|divisor|}.
  - If diff is negative (borrow), work ← work<<1.
  - Else work ← {diff[W-1:0], work[W-1:0], 1'b1}.
  - cnt++.
- ON, cnt reaches WIDTH:
  - The final iteration is done on the cycle cnt=WIDTH−1.
  - Sign fix-up: quotient negated when signed and the operand signs differ; remainder negated when signed and the dividend is negative. Remainder is taken from work[2W:W+1].
  - Result registered; → END.
- ON, annul_i=1: → IDLE on the next edge, cnt←0, no result produced.
- END: ready_o=1, result_o held. When start_i=0 → IDLE, ready_o←0, result_o←0. annul_i is ignored in END.
- start_i dropping in ON without annul_i: iteration continues to END, then returns to IDLE on the next edge. The result is discarded by EX.
- Signed overflow −2^(W−1) / −1: quotient 0x8000_0000, remainder 0. This is the natural wrap; no flag.
- Operands are sampled only in IDLE. Changes to operands during ON or END have no effect.

## Timing

- Reset (async) values: state=IDLE, cnt=0, work=0, ready_o=0, result_o=0. stallreq_o follows start_i.
- Edge E0 samples start_i in IDLE. Iterations run on E1..EWIDTH. ready_o is high after edge E(WIDTH+1): 33 clocks for W=32.
- Divide by zero: ready_o is high after E2.
- ready_o stays high until the first edge where start_i=0. It falls after that edge.
- A back-to-back op needs start_i low for at least one cycle, giving an IDLE cycle between ops.
- stallreq_o is high from the cycle start_i rises up to, but not including, the cycle ready_o is high.
- Reset asserted mid-ON: state is immediately IDLE and outputs 0; no partial result is visible.
- annul_i and start_i both high in IDLE: no start.

## Test plan

- Unsigned 100 / 7:
  - ready_o rises 33 clocks after start_i.
  - result_o = {32'd2, 32'd14}.
  - stallreq_o is high for exactly 33 cycles.
- Signed −7 / 2 (0xFFFF_FFF9 / 0x2): quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF. Also signed 7 / −2: quotient 0xFFFF_FFFD, remainder 0x1.
- Divide by zero, 0x1234 / 0: ready_o after 2 clocks, result_o=0. Dropping start_i → ready_o=0 and state IDLE next cycle.
- Annul:
  - Start 1000 / 3; pulse annul_i at iteration 10.
  - ready_o never rises; IDLE next cycle.
  - A following 9 / 3 yields {0, 3} in 33 clocks.
- Async reset asserted mid-ON (iteration 20): outputs 0 immediately without a clock. After release, 0xFFFF_FFFF / 1 unsigned yields {0, 0xFFFF_FFFF}.
- Signed 0x8000_0000 / 0xFFFF_FFFF → {0, 0x8000_0000}. Holding start_i high in END keeps result_o stable for at least 5 cycles.
